vga_timing_gen: RTL and testbench

Raster timing generator producing the pixel coordinates, pixel strobe and sync signals consumed by every text/graphics overlay in the display path (start screen, board, score text). It is the driving end of the pix_x/pix_y/pixel_tick interface: overlays only read coordinates and present RGB; this block owns the raster counters. It sits between the system clock and the VGA connector, alongside the RGB output mux.

---
 rtl/vga_timing_gen_if.sv | 30 +++
 rtl/vga_timing_gen.sv | 102 ++++++++++
 tb/tb_vga_timing_gen.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle shared between the timing generator and its consumers.
//   en          : run enable into the generator (low freezes the raster)
//   pixel_tick  : one-clk strobe per pixel period
//   pix_x/pix_y : current raster coordinates
//   video_on    : inside the visible area
//   hsync/vsync : active-low sync pulses
//   line_start  : pulse on the tick that wraps pix_x to 0
//   frame_start : pulse on the tick that wraps to (0,0)
// master = generator side, slave = consumer/controller side.
interface vga_timing_gen_if;
    logic       en;
    logic       pixel_tick;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;

    modport master (
        input  en,
        output pixel_tick, pix_x, pix_y, video_on, hsync, vsync, line_start, frame_start
    );

    modport slave (
        output en,
        input  pixel_tick, pix_x, pix_y, video_on, hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Owns the pixel divider and the horizontal and
// vertical raster counters; decodes sync and visible-area flags.
// Ports:
//   clk    : system clock (only clock)
//   reset  : synchronous, active-high reset
//   raster : vga_timing_gen_if.master (en in; tick, coordinates, syncs out)
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int TICK_DIV = 2
) (
    input  logic               clk,
    input  logic               reset,
    vga_timing_gen_if.master   raster
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_ACTIVE = 10'(H_ACTIVE);
    localparam logic [9:0] Y_ACTIVE = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_q, video_d;
    logic             tick;
    logic             x_wrap;
    logic             y_wrap;

    always_comb begin
        // Reset gates the strobe so nothing downstream sees a tick while held.
        tick    = raster.en && !reset && (div_q == DIV_LAST);
        x_wrap  = (x_q == X_LAST);
        y_wrap  = (y_q == Y_LAST);

        div_d   = div_q;
        x_d     = x_q;
        y_d     = y_q;

        if (raster.en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end

        if (tick) begin
            if (x_wrap) begin
                x_d = '0;
                y_d = y_wrap ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end

        // Decode the next-state coordinates so the flags switch on the same
        // edge as pix_x/pix_y and come straight from flops.
        hsync_d = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
        vsync_d = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
        video_d = (x_d < X_ACTIVE) && (y_d < Y_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            video_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
        end
    end

    assign raster.pixel_tick  = tick;
    assign raster.line_start  = tick && x_wrap;
    assign raster.frame_start = tick && x_wrap && y_wrap;
    assign raster.pix_x       = x_q;
    assign raster.pix_y       = y_q;
    assign raster.hsync       = hsync_q;
    assign raster.vsync       = vsync_q;
    assign raster.video_on    = video_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if ia ();
    vga_timing_gen_if ib ();

    // Full 640x480 timing, TICK_DIV=2.
    vga_timing_gen dut_a (
        .clk    (clk),
        .reset  (reset_a),
        .raster (ia)
    );

    // Miniature raster: H 8/2/3/2 (total 15), V 4/1/2/1 (total 8), TICK_DIV=3.
    // hsync low at x=10..12, vsync low at y=5..6, frame = 15*8*3 = 360 clks.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .TICK_DIV(3)
    ) dut_b (
        .clk    (clk),
        .reset  (reset_b),
        .raster (ib)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset_a = 1'b1; reset_b = 1'b1; ia.en = 1'b1; ib.en = 1'b1;
        repeat (3) step();
        checks++; if (ia.pix_x !== 10'd0) begin failures++; $display("FAIL rst_pix_x got=%0d exp=0", ia.pix_x); end
        checks++; if (ia.pix_y !== 10'd0) begin failures++; $display("FAIL rst_pix_y got=%0d exp=0", ia.pix_y); end
        checks++; if (ia.pixel_tick !== 1'b0) begin failures++; $display("FAIL rst_tick got=%b exp=0", ia.pixel_tick); end
        checks++; if (ia.video_on !== 1'b0) begin failures++; $display("FAIL rst_video got=%b exp=0", ia.video_on); end
        checks++; if ({ia.hsync, ia.vsync} !== 2'b11) begin failures++; $display("FAIL rst_sync got=%b%b exp=11", ia.hsync, ia.vsync); end
        checks++; if ({ib.pixel_tick, ib.line_start, ib.frame_start} !== 3'b000) begin failures++; $display("FAIL rst_b_strobes got=%b exp=000", {ib.pixel_tick, ib.line_start, ib.frame_start}); end
        // Release dut_a; this cycle is clk 0 after release.
        reset_a = 1'b0;
        #1;
        checks++; if ({ia.pixel_tick, ia.video_on} !== 2'b00) begin failures++; $display("FAIL rel_c0 tick_video got=%b exp=00", {ia.pixel_tick, ia.video_on}); end
        step();
        checks++; if ({ia.pixel_tick, ia.video_on, ia.hsync, ia.vsync} !== 4'b1111) begin failures++; $display("FAIL rel_c1 tick_video_hs_vs got=%b exp=1111", {ia.pixel_tick, ia.video_on, ia.hsync, ia.vsync}); end
        checks++; if (ia.pix_x !== 10'd0) begin failures++; $display("FAIL rel_c1 pix_x got=%0d exp=0", ia.pix_x); end
        step();
        checks++; if ({ia.pixel_tick, ia.pix_x} !== {1'b0, 10'd1}) begin failures++; $display("FAIL rel_c2 tick=%b pix_x=%0d exp tick=0 pix_x=1", ia.pixel_tick, ia.pix_x); end
        step();
        checks++; if (ia.pixel_tick !== 1'b1) begin failures++; $display("FAIL rel_c3 tick got=%b exp=1", ia.pixel_tick); end
        step();
        checks++; if (ia.pix_x !== 10'd2) begin failures++; $display("FAIL rel_c4 pix_x got=%0d exp=2", ia.pix_x); end
    endtask

    // Entered at clk 4 after release: pix_x = n/2, tick on odd n.
    task automatic test_line();
        int hs_low = 0;
        int first_hs = -1;
        int ls_cnt = 0;
        int ls_x = -1;
        for (int n = 4; n <= 1600; n++) begin
            if (ia.hsync === 1'b0) begin
                hs_low++;
                if (first_hs < 0) first_hs = int'(ia.pix_x);
            end
            if (ia.line_start === 1'b1) begin
                ls_cnt++;
                ls_x = int'(ia.pix_x);
            end
            if (n == 1599) begin
                checks++; if ({ia.pix_x, ia.pix_y, ia.pixel_tick, ia.line_start} !== {10'd799, 10'd0, 1'b1, 1'b1}) begin failures++; $display("FAIL line_end x=%0d y=%0d tick=%b ls=%b exp 799 0 1 1", ia.pix_x, ia.pix_y, ia.pixel_tick, ia.line_start); end
            end
            if (n == 1600) begin
                checks++; if ({ia.pix_x, ia.pix_y} !== {10'd0, 10'd1}) begin failures++; $display("FAIL line_wrap x=%0d y=%0d exp 0 1", ia.pix_x, ia.pix_y); end
            end
            step();
        end
        checks++; if (hs_low != 192) begin failures++; $display("FAIL hsync_width got=%0d exp=192", hs_low); end
        checks++; if (first_hs != 656) begin failures++; $display("FAIL hsync_start_x got=%0d exp=656", first_hs); end
        checks++; if (ls_cnt != 1) begin failures++; $display("FAIL line_start_count got=%0d exp=1", ls_cnt); end
        checks++; if (ls_x != 799) begin failures++; $display("FAIL line_start_x got=%0d exp=799", ls_x); end
    endtask

    // Entered at clk 1601 (pix_x=0, div=1, line 1).
    task automatic test_freeze();
        repeat (600) step();
        checks++; if ({ia.pix_x, ia.pixel_tick} !== {10'd300, 1'b1}) begin failures++; $display("FAIL frz_pre x=%0d tick=%b exp 300 1", ia.pix_x, ia.pixel_tick); end
        ia.en = 1'b0;
        #1;
        checks++; if (ia.pixel_tick !== 1'b0) begin failures++; $display("FAIL frz_tick_now got=%b exp=0", ia.pixel_tick); end
        for (int k = 0; k < 7; k++) begin
            step();
            checks++;
            if ({ia.pix_x, ia.pix_y, ia.pixel_tick, ia.line_start, ia.video_on, ia.hsync, ia.vsync} !== {10'd300, 10'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}) begin
                failures++;
                $display("FAIL frz_hold k=%0d x=%0d y=%0d tick=%b ls=%b vid=%b hs=%b vs=%b exp 300 1 0 0 1 1 1", k, ia.pix_x, ia.pix_y, ia.pixel_tick, ia.line_start, ia.video_on, ia.hsync, ia.vsync);
            end
        end
        ia.en = 1'b1;
        #1;
        checks++; if ({ia.pixel_tick, ia.pix_x} !== {1'b1, 10'd300}) begin failures++; $display("FAIL frz_resume tick=%b x=%0d exp 1 300", ia.pixel_tick, ia.pix_x); end
        step();
        checks++; if ({ia.pixel_tick, ia.pix_x} !== {1'b0, 10'd301}) begin failures++; $display("FAIL frz_after tick=%b x=%0d exp 0 301", ia.pixel_tick, ia.pix_x); end
        step();
    endtask

    // Entered at (301, div=1): after 676 clks at (639, div=1).
    task automatic test_video_edge_x();
        repeat (676) step();
        checks++; if ({ia.pix_x, ia.video_on} !== {10'd639, 1'b1}) begin failures++; $display("FAIL vid_639 x=%0d vid=%b exp 639 1", ia.pix_x, ia.video_on); end
        step();
        checks++; if ({ia.pix_x, ia.video_on, ia.hsync} !== {10'd640, 1'b0, 1'b1}) begin failures++; $display("FAIL vid_640 x=%0d vid=%b hs=%b exp 640 0 1", ia.pix_x, ia.video_on, ia.hsync); end
    endtask

    // Two frames of the miniature raster checked every clk against
    // P = j/3, x = P%15, y = (P/15)%8, tick on j%3==2.
    task automatic test_frame();
        int vs_low = 0;
        int vs_first = -1;
        int fs_cnt = 0;
        int fs_j0 = -1;
        int fs_j1 = -1;
        int p, x, y;
        logic tk, vid, hs, vs;
        logic [25:0] got, exp_v;
        reset_b = 1'b0;
        #1;
        for (int j = 0; j <= 730; j++) begin
            p   = j / 3;
            x   = p % 15;
            y   = (p / 15) % 8;
            tk  = (j % 3 == 2);
            vid = (j == 0) ? 1'b0 : ((x < 8) && (y < 4));
            hs  = !((x >= 10) && (x <= 12));
            vs  = !((y >= 5) && (y <= 6));
            exp_v = {10'(x), 10'(y), tk, tk && (x == 14), tk && (x == 14) && (y == 7), vid, hs, vs};
            got   = {ib.pix_x, ib.pix_y, ib.pixel_tick, ib.line_start, ib.frame_start, ib.video_on, ib.hsync, ib.vsync};
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL frame_j%0d got x=%0d y=%0d flags=%b exp x=%0d y=%0d flags=%b", j, got[25:16], got[15:6], got[5:0], x, y, exp_v[5:0]);
            end
            if (j < 360 && ib.vsync === 1'b0) begin
                vs_low++;
                if (vs_first < 0) vs_first = j;
            end
            if (ib.frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_j0 < 0) fs_j0 = j; else fs_j1 = j;
            end
            step();
        end
        checks++; if (vs_low != 90) begin failures++; $display("FAIL vsync_width got=%0d exp=90", vs_low); end
        checks++; if (vs_first != 225) begin failures++; $display("FAIL vsync_start_clk got=%0d exp=225", vs_first); end
        checks++; if (fs_cnt != 2) begin failures++; $display("FAIL frame_start_count got=%0d exp=2", fs_cnt); end
        checks++; if (fs_j0 != 359 || fs_j1 != 719) begin failures++; $display("FAIL frame_start_clks got=%0d,%0d exp=359,719", fs_j0, fs_j1); end
    endtask

    task automatic test_reset_mid();
        int budget = 400;
        while (budget > 0 && !(ib.pix_x == 10'd12 && ib.pix_y == 10'd6)) begin
            step();
            budget--;
        end
        checks++; if (budget == 0) begin failures++; $display("FAIL midrst_wait got=timeout exp=reach (12,6)"); end
        checks++; if ({ib.hsync, ib.vsync} !== 2'b00) begin failures++; $display("FAIL midrst_pre hs_vs got=%b%b exp=00", ib.hsync, ib.vsync); end
        reset_b = 1'b1;
        step();
        checks++;
        if ({ib.pix_x, ib.pix_y, ib.hsync, ib.vsync, ib.video_on, ib.pixel_tick} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midrst_state x=%0d y=%0d hs=%b vs=%b vid=%b tick=%b exp 0 0 1 1 0 0", ib.pix_x, ib.pix_y, ib.hsync, ib.vsync, ib.video_on, ib.pixel_tick);
        end
        reset_b = 1'b0;
        step();
        checks++; if ({ib.video_on, ib.pixel_tick} !== 2'b10) begin failures++; $display("FAIL midrst_c1 vid_tick got=%b exp=10", {ib.video_on, ib.pixel_tick}); end
        step();
        checks++; if (ib.pixel_tick !== 1'b1) begin failures++; $display("FAIL midrst_c2 tick got=%b exp=1", ib.pixel_tick); end
        step();
        checks++; if ({ib.pix_x, ib.pixel_tick} !== {10'd1, 1'b0}) begin failures++; $display("FAIL midrst_c3 x=%0d tick=%b exp 1 0", ib.pix_x, ib.pixel_tick); end
    endtask

    initial begin
        test_reset();
        test_line();
        test_freeze();
        test_video_edge_x();
        test_frame();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
